db_cont_assoc: RTL

Parametrised, set-associative successor to the single-way filter database controller. It looks up a key in a WAYS-way hash table held in internal synchronous RAM and answers GET requests with hit and filter-state flags. SET requests insert, refresh, escalate or invalidate entries, with timestamp-based expiry and round-robin eviction. It sits between the packet-parser hash stage and the filter/drop logic.

---
 rtl/db_cont_assoc.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/db_cont_assoc.sv
// db_cont_assoc: WAYS-way set-associative filter database with timestamp expiry and round-robin eviction.
// Optional statistics counters are built only when DB_STATS_EN is defined.
module db_cont_assoc #(
  parameter int KEY_SIZE  = 96,
  parameter int HASH_SIZE = 32,
  parameter int RAM_ADDR  = 10,
  parameter int WAYS      = 2,
  parameter int TS_WIDTH  = 16,
  parameter int TICK_DIV  = 65536,
  parameter int LIFETIME  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [HASH_SIZE-1:0] in_hash,
  input  logic [KEY_SIZE-1:0]  in_key,
  output logic                 out_valid,
  output logic                 out_hit,
  output logic [3:0]           out_flag,
  output logic [31:0]          stat_hit,
  output logic [31:0]          stat_miss,
  output logic [31:0]          stat_evict
);
  localparam int SETS = 2**RAM_ADDR;
  localparam int VW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef struct packed {
    logic                v;
    logic [KEY_SIZE-1:0] key;
    logic [1:0]          st;
    logic [TS_WIDTH-1:0] ts;
  } ent_t;
  typedef enum logic [1:0] {INIT, IDLE, LOOKUP, COMMIT} state_t;
  state_t              state_q;
  logic [RAM_ADDR-1:0] init_q, idx_q;
  logic [KEY_SIZE-1:0] key_q;
  logic [2:0]          op_q;
  logic [TS_WIDTH-1:0] now_q;
  logic [PW-1:0]       pre_q;
  logic [VW-1:0]       vp_q, wr_way_q, wr_way_d, hw, ew, fw;
  logic                wr_en_q, wr_en_d, hit_d, em, fr, evict_d, tick;
  ent_t                wr_ent_q, wr_ent_d;
  ent_t                rd [WAYS];
  logic [WAYS-1:0]     alive, match;
  logic [1:0]          req;
  logic                unused_bits;
  assign unused_bits = ^{in_op[3], in_hash[HASH_SIZE-1:RAM_ADDR]};
  assign tick = pre_q == PW'(TICK_DIV-1);
  assign req = op_q[2:1];
  // One RAM per way so INIT can clear a whole set in a single cycle.
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    ent_t ram [SETS];
    ent_t rd_q;
    always_ff @(posedge clk) begin
      if (state_q == IDLE && in_valid) rd_q <= ram[in_hash[RAM_ADDR-1:0]];
      if (state_q == INIT) ram[init_q] <= '0;
      else if (state_q == COMMIT && wr_en_q && wr_way_q == VW'(g)) ram[idx_q] <= wr_ent_q;
    end
    assign rd[g] = rd_q;
    assign alive[g] = rd_q.v && (TS_WIDTH'(now_q - rd_q.ts) < TS_WIDTH'(LIFETIME));
    assign match[g] = rd_q.v && rd_q.key == key_q;
  end
  always_comb begin
    hit_d = 1'b0;
    em = 1'b0;
    fr = 1'b0;
    hw = '0;
    ew = '0;
    fw = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (alive[w] && match[w]) begin
        hit_d = 1'b1;
        hw = VW'(w);
      end
      if (match[w] && !alive[w]) begin
        em = 1'b1;
        ew = VW'(w);
      end
      if (!alive[w]) begin
        fr = 1'b1;
        fw = VW'(w);
      end
    end
    wr_en_d = 1'b0;
    wr_way_d = hw;
    wr_ent_d = rd[hw];
    evict_d = 1'b0;
    if (op_q[0] && hit_d) begin
      wr_en_d = req != 2'b00;
      wr_ent_d.v = req != 2'b11;
      wr_ent_d.ts = (req[0] ^ req[1]) ? now_q : rd[hw].ts;
      wr_ent_d.st = req == 2'b10 ? 2'b10 : rd[hw].st;
    end else if (op_q[0] && (req[0] ^ req[1])) begin
      wr_en_d = 1'b1;
      evict_d = !em && !fr;
      wr_way_d = em ? ew : fr ? fw : vp_q;
      wr_ent_d = '{1'b1, key_q, req, now_q};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      init_q <= '0;
      idx_q <= '0;
      key_q <= '0;
      op_q <= '0;
      now_q <= '0;
      pre_q <= '0;
      vp_q <= '0;
      wr_en_q <= 1'b0;
      wr_way_q <= '0;
      wr_ent_q <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_hit <= 1'b0;
      out_flag <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      now_q <= now_q + TS_WIDTH'(tick);
      out_valid <= 1'b0;
      case (state_q)
        INIT: begin
          init_q <= init_q + 1'b1;
          if (&init_q) begin
            state_q <= IDLE;
            in_ready <= 1'b1;
          end
        end
        IDLE: if (in_valid) begin
          idx_q <= in_hash[RAM_ADDR-1:0];
          key_q <= in_key;
          op_q <= in_op[2:0];
          in_ready <= 1'b0;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          out_valid <= 1'b1;
          out_hit <= hit_d;
          out_flag <= hit_d ? {1'b0, rd[hw].st, 1'b1} : 4'b0;
          wr_en_q <= wr_en_d;
          wr_way_q <= wr_way_d;
          wr_ent_q <= wr_ent_d;
          if (evict_d) vp_q <= (vp_q == VW'(WAYS-1)) ? '0 : vp_q + 1'b1;
          state_q <= COMMIT;
        end
        default: begin
          wr_en_q <= 1'b0;
          in_ready <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
`ifdef DB_STATS_EN
  logic [31:0] hit_q, miss_q, evict_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
      miss_q <= '0;
      evict_q <= '0;
    end else if (state_q == LOOKUP) begin
      hit_q <= hit_q + 32'(!op_q[0] && hit_d && !(&hit_q));
      miss_q <= miss_q + 32'(!op_q[0] && !hit_d && !(&miss_q));
      evict_q <= evict_q + 32'(evict_d && !(&evict_q));
    end
  end
  assign stat_hit = hit_q;
  assign stat_miss = miss_q;
  assign stat_evict = evict_q;
`else
  assign stat_hit = '0;
  assign stat_miss = '0;
  assign stat_evict = '0;
`endif
endmodule
